// File: rtl/seg7_dimmer.sv
// Output-stage conditioner for the 7-segment display: PWM brightness with optional fade,
// per-digit blink and global blank, programmed through two write-only bus registers.
module seg7_dimmer #(
    parameter logic [7:0] BASE_ADDR    = 8'hD2,
    parameter int         PWM_STEP_DIV = 390,
    parameter int         BLINK_DIV    = 25000000,
    parameter int         FADE_DIV     = 1562500
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [3:0] SEL_IN,
    input  logic [7:0] SEG_IN,
    output logic [3:0] DISP_SEL_OUT,
    output logic [7:0] DISP_OUT
);
    localparam int PWM_W   = $clog2(PWM_STEP_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int FADE_W  = $clog2(FADE_DIV + 1);

    localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_STEP_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_DIV - 1);
    localparam logic [7:0]         CTRL_ADDR  = BASE_ADDR + 8'd1;
    localparam logic [4:0]         MAX_LEVEL  = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fadeState_t;

    logic [4:0]         target;
    logic [4:0]         level;
    logic [7:0]         ctrl;
    logic [PWM_W-1:0]   pwmDiv;
    logic [3:0]         pwmPhase;
    logic [BLINK_W-1:0] blinkDiv;
    logic               blinkPhase;
    logic [FADE_W-1:0]  fadeDiv;
    fadeState_t         fadeState;

    // Output gating, evaluated from pre-edge register values.
    logic [3:0] selActive;
    logic       oneHot;
    logic       lit;
    logic       blinkOff;
    logic       show;

    assign selActive = ~SEL_IN;
    assign oneHot    = (selActive != 4'd0) && ((selActive & (selActive - 4'd1)) == 4'd0);
    assign lit       = ({1'b0, pwmPhase} < level);
    assign blinkOff  = blinkPhase & (|(ctrl[3:0] & selActive));
    assign show      = lit & ~ctrl[7] & ~blinkOff & oneHot;

    logic       wantUp;
    logic       wantDown;
    logic [4:0] stepLevel;
    fadeState_t dirState;

    assign wantUp    = (target > level);
    assign wantDown  = (target < level);
    assign stepLevel = wantUp ? level + 5'd1 : level - 5'd1;
    assign dirState  = wantUp ? UP : DOWN;

    // NOTE: every register below uses non-blocking assignments so all updates on one edge
    // see the same pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            target <= MAX_LEVEL;
            ctrl   <= 8'h00;
        end else if (BUS_WE) begin
            if (BUS_ADDR == BASE_ADDR)
                target <= (BUS_DATA > 8'd16) ? MAX_LEVEL : BUS_DATA[4:0];
            else if (BUS_ADDR == CTRL_ADDR)
                ctrl <= BUS_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwmDiv     <= '0;
            pwmPhase   <= 4'd0;
            blinkDiv   <= '0;
            blinkPhase <= 1'b0;
        end else begin
            if (pwmDiv == PWM_LAST) begin
                pwmDiv   <= '0;
                pwmPhase <= pwmPhase + 4'd1;
            end else begin
                pwmDiv <= pwmDiv + PWM_W'(1);
            end
            if (blinkDiv == BLINK_LAST) begin
                blinkDiv   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkDiv <= blinkDiv + BLINK_W'(1);
            end
        end
    end

    // A direction reversal mid-ramp keeps the divider running, so the next step lands on schedule.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            level     <= MAX_LEVEL;
            fadeDiv   <= '0;
            fadeState <= IDLE;
        end else if (!ctrl[6]) begin
            level     <= target;
            fadeDiv   <= '0;
            fadeState <= IDLE;
        end else begin
            case (fadeState)
                IDLE: begin
                    fadeDiv <= '0;
                    if (wantUp)
                        fadeState <= UP;
                    else if (wantDown)
                        fadeState <= DOWN;
                end
                default: begin
                    if (!wantUp && !wantDown) begin
                        fadeDiv   <= '0;
                        fadeState <= IDLE;
                    end else if (fadeDiv == FADE_LAST) begin
                        fadeDiv   <= '0;
                        level     <= stepLevel;
                        fadeState <= (stepLevel == target) ? IDLE : dirState;
                    end else begin
                        fadeDiv   <= fadeDiv + FADE_W'(1);
                        fadeState <= dirState;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DISP_SEL_OUT <= 4'hF;
            DISP_OUT     <= 8'hFF;
        end else if (show) begin
            DISP_SEL_OUT <= SEL_IN;
            DISP_OUT     <= SEG_IN;
        end else begin
            DISP_SEL_OUT <= 4'hF;
            DISP_OUT     <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg7_dimmer.sv
// Directed bench for seg7_dimmer: passthrough, PWM duty, blink, blank, fade ramps and fade disable.
`timescale 1ns/1ps
module tb_seg7_dimmer;
    logic       CLK;
    logic       RESET_N;
    logic [7:0] busData;
    logic [7:0] busAddr;
    logic       busWe;
    logic [3:0] selIn;
    logic [7:0] segIn;
    logic [3:0] dispSelOut;
    logic [7:0] dispOut;

    int assertCount = 0;
    int failCount   = 0;

    seg7_dimmer #(
        .BASE_ADDR(8'hD2),
        .PWM_STEP_DIV(2),
        .BLINK_DIV(8),
        .FADE_DIV(4)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .BUS_DATA(busData),
        .BUS_ADDR(busAddr),
        .BUS_WE(busWe),
        .SEL_IN(selIn),
        .SEG_IN(segIn),
        .DISP_SEL_OUT(dispSelOut),
        .DISP_OUT(dispOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one write at a falling edge; it lands on the following rising edge.
    task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
        busAddr = addr;
        busData = data;
        busWe   = 1'b1;
        @(negedge CLK);
        busWe   = 1'b0;
        busAddr = 8'h00;
        busData = 8'h00;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Sample n cycles: lit = passthrough of inputs, bad = neither passthrough nor fully dark,
    // altErr = samples that equal the one 8 cycles later (blink square-wave property).
    task automatic measure(input int n, output int litCnt, output int badCnt, output int altErr);
        bit samp[64];
        litCnt = 0;
        badCnt = 0;
        altErr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            samp[i] = 1'b0;
            if (dispSelOut == selIn && dispOut == segIn && selIn != 4'hF) begin
                litCnt++;
                samp[i] = 1'b1;
            end else if (!(dispSelOut == 4'hF && dispOut == 8'hFF)) begin
                badCnt++;
            end
        end
        for (int i = 0; i + 8 < n; i++)
            if (samp[i] == samp[i+8]) altErr++;
    endtask

    int litCnt, badCnt, altErr;

    initial begin
        RESET_N = 1'b0;
        busData = 8'h00;
        busAddr = 8'h00;
        busWe   = 1'b0;
        selIn   = 4'b1110;
        segIn   = 8'hC0;

        waitCycles(3);
        check("reset_sel", {28'd0, dispSelOut}, 32'hF);
        check("reset_seg", {24'd0, dispOut}, 32'hFF);
        check("reset_level", {27'd0, dut.level}, 32'd16);
        check("reset_target", {27'd0, dut.target}, 32'd16);
        RESET_N = 1'b1;

        measure(32, litCnt, badCnt, altErr);
        check("passthrough_lit", litCnt, 32);
        check("passthrough_bad", badCnt, 0);

        // Asynchronous reset mid-run: outputs dark before the next rising edge.
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_sel", {28'd0, dispSelOut}, 32'hF);
        check("async_reset_seg", {24'd0, dispOut}, 32'hFF);
        @(negedge CLK);
        RESET_N = 1'b1;

        // PWM duty with fade off.
        busWrite(8'hD2, 8'd4);
        waitCycles(1);
        measure(32, litCnt, badCnt, altErr);
        check("pwm4_lit", litCnt, 8);
        check("pwm4_bad", badCnt, 0);

        busWrite(8'hD2, 8'd0);
        waitCycles(1);
        measure(32, litCnt, badCnt, altErr);
        check("pwm0_lit", litCnt, 0);

        busWrite(8'hD2, 8'hFF);
        waitCycles(1);
        check("sat_target", {27'd0, dut.target}, 32'd16);
        measure(32, litCnt, badCnt, altErr);
        check("pwm16_lit", litCnt, 32);

        // Blink on digit 0.
        busWrite(8'hD3, 8'h01);
        waitCycles(1);
        measure(32, litCnt, badCnt, altErr);
        check("blink_lit", litCnt, 16);
        check("blink_alternate", altErr, 0);
        check("blink_bad", badCnt, 0);

        selIn = 4'b1101;
        segIn = 8'h7F;
        measure(32, litCnt, badCnt, altErr);
        check("blink_other_digit", litCnt, 32);

        // Global blank, then invalid select with no blank.
        busWrite(8'hD3, 8'h80);
        waitCycles(1);
        measure(32, litCnt, badCnt, altErr);
        check("blank_lit", litCnt, 0);
        check("blank_bad", badCnt, 0);

        busWrite(8'hD3, 8'h00);
        selIn = 4'b1100;
        waitCycles(1);
        measure(32, litCnt, badCnt, altErr);
        check("badsel_lit", litCnt, 0);
        check("badsel_bad", badCnt, 0);
        selIn = 4'b1110;
        segIn = 8'hC0;

        // Fade down 16 -> 12: one step every 4 clocks after entering DOWN.
        busWrite(8'hD3, 8'h40);
        busWrite(8'hD2, 8'd12);
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            check($sformatf("fade_level_k%0d", k), {27'd0, dut.level}, 32'(16 - (k - 1) / 4));
            if (k == 1 || k == 16)
                check($sformatf("fade_state_k%0d", k), {30'd0, dut.fadeState}, 32'd2);
        end
        check("fade_idle", {30'd0, dut.fadeState}, 32'd0);

        // Ramp back to 16, descend again and reverse at level 13.
        busWrite(8'hD2, 8'd16);
        waitCycles(20);
        check("fade_up_level", {27'd0, dut.level}, 32'd16);
        check("fade_up_idle", {30'd0, dut.fadeState}, 32'd0);
        busWrite(8'hD2, 8'd12);
        waitCycles(13);
        check("rev_pre_level", {27'd0, dut.level}, 32'd13);
        busWrite(8'hD2, 8'd14);
        waitCycles(2);
        check("rev_mid_level", {27'd0, dut.level}, 32'd13);
        check("rev_mid_state", {30'd0, dut.fadeState}, 32'd1);
        waitCycles(1);
        check("rev_end_level", {27'd0, dut.level}, 32'd14);
        check("rev_end_state", {30'd0, dut.fadeState}, 32'd0);

        // Fade disable mid-ramp snaps level to target.
        busWrite(8'hD2, 8'd16);
        waitCycles(12);
        check("pre_dis_level", {27'd0, dut.level}, 32'd16);
        busWrite(8'hD2, 8'd0);
        waitCycles(6);
        check("dis_mid_level", {27'd0, dut.level}, 32'd15);
        check("dis_mid_state", {30'd0, dut.fadeState}, 32'd2);
        busWrite(8'hD3, 8'h00);
        waitCycles(1);
        check("dis_level", {27'd0, dut.level}, 32'd0);
        check("dis_state", {30'd0, dut.fadeState}, 32'd0);

        // Unmapped address is ignored.
        busWrite(8'hD4, 8'h55);
        waitCycles(1);
        check("unmapped_ctrl", {24'd0, dut.ctrl}, 32'h00);
        check("unmapped_target", {27'd0, dut.target}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seg7_dimmer.md
Name: seg7_dimmer

Overview:
- Output-stage conditioner between the 7-segment display controller (base 0xD0/0xD1) and the board pins.
- Takes the strobed, active-low digit-select and segment vectors that controller produces and applies PWM brightness, per-digit blink and global blank.
- Brightness and control are bus-programmable registers at 0xD2/0xD3 on the main bus.
- Brightness changes can ramp gradually (fade) or take effect immediately.

Parameters:
BASE_ADDR, 8'hD2, brightness register address; control register is BASE_ADDR+1
PWM_STEP_DIV, 390, clocks per PWM phase step; PWM period = 16*PWM_STEP_DIV clocks
BLINK_DIV, 25000000, clocks per blink phase toggle
FADE_DIV, 1562500, clocks per one-level fade step

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
BUS_DATA  in  8  main bus write data
BUS_ADDR  in  8  main bus address
BUS_WE  in  1  main bus write enable
SEL_IN  in  4  digit select from display controller, active-low, one-hot-low
SEG_IN  in  8  segment pattern from display controller, active-low, bit7 = dp
DISP_SEL_OUT  out  4  digit select to pins, active-low
DISP_OUT  out  8  segments to pins, active-low

Behaviour:
- Interface: one clock CLK; reset RESET_N is asynchronous and active-low. All state is cleared on RESET_N=0, regardless of clock.
- Reset values:
  - DISP_SEL_OUT=4'hF, DISP_OUT=8'hFF.
  - target=16, level=16, ctrl=8'h00.
  - pwm_phase=0, all dividers=0, blink_phase=0, FSM=IDLE.
- Register writes take effect on the CLK edge where BUS_WE=1 and the address matches. Writes to other addresses are ignored. Registers are write-only; the block never drives the bus.
- Brightness write (BASE_ADDR): target <= min(BUS_DATA, 16); 5-bit value, values 17..255 saturate to 16.
- Control write (BASE_ADDR+1): ctrl <= BUS_DATA.
  - ctrl[3:0]: per-digit blink enable; bit i refers to SEL_IN[i].
  - ctrl[6]: fade enable.
  - ctrl[7]: global blank.
  - ctrl[5:4]: reserved, stored, no effect.
- PWM:
  - step divider counts 0..PWM_STEP_DIV-1; on wrap, pwm_phase (4-bit) increments modulo 16.
  - lit = (pwm_phase < level), compared at 5 bits. level 0 = always dark; level 16 = always lit.
- Blink:
  - divider counts 0..BLINK_DIV-1; on wrap, blink_phase toggles.
  - blink_off = blink_phase & |(ctrl[3:0] & ~SEL_IN).
- Gate: show = lit & ~ctrl[7] & ~blink_off & (SEL_IN is exactly one-hot-low).
- Output registers, 1-cycle latency from SEL_IN/SEG_IN:
  - show=1: DISP_SEL_OUT <= SEL_IN, DISP_OUT <= SEG_IN.
  - show=0: DISP_SEL_OUT <= 4'hF, DISP_OUT <= 8'hFF.
- Fade FSM, states IDLE, UP, DOWN:
  - IDLE: target>level -> UP; target<level -> DOWN; fade divider held at 0.
  - UP/DOWN: fade divider counts 0..FADE_DIV-1; on wrap, level +/-1. When level==target after a step -> IDLE.
  - First step occurs exactly FADE_DIV clocks after entering UP/DOWN.
  - Target rewritten mid-ramp: direction is re-evaluated each cycle; a reversal switches state without resetting the divider; target==level -> IDLE.
  - ctrl[6]=0: level <= target on the cycle after any change, and FSM stays IDLE. Clearing ctrl[6] mid-ramp snaps level to target next cycle.
- Simultaneous events: a register write, PWM wrap, blink toggle and fade step on the same edge are all applied. Gating uses pre-edge register values.
- RESET_N asserted mid-ramp or mid-blink: immediate return to reset values. Outputs go dark asynchronously.

Test Plan:
Bench parameters: PWM_STEP_DIV=2, BLINK_DIV=8, FADE_DIV=4.
- Reset passthrough: release reset, SEL_IN=4'b1110, SEG_IN=8'hC0 -> DISP_SEL_OUT=4'b1110, DISP_OUT=8'hC0 from the 2nd edge, every cycle (level 16). RESET_N low mid-run -> 4'hF/8'hFF immediately, before the next edge.
- PWM duty: fade off, write 0xD2=4 -> over 32-clock period, exactly 8 lit cycles. Write 0 -> 0 lit. Write 0xFF -> saturates to 16, all 32 lit.
- Blink: write 0xD3=8'h01, SEL_IN=4'b1110 -> output alternates 8 lit / 8 dark cycles. SEL_IN=4'b1101 -> always lit.
- Blank and invalid select: 0xD3=8'h80 -> always 4'hF/8'hFF. ctrl=0 with SEL_IN=4'b1100 -> dark.
- Fade: 0xD3=8'h40, then 0xD2=12 -> level 16->12, one step per 4 clocks, IDLE after 16 clocks. Write 14 when level=13 -> reverses to UP, reaches 14 four clocks later.
- Fade disable: 0xD3=8'h40, write 0xD2=0, mid-ramp write 0xD3=8'h00 -> level=0 on next cycle, FSM IDLE. Write to 0xD4 -> no register change.
